// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types for the 5-stage core pipeline registers.
//   ex_mem_ctrl_t : EX/MEM control bundle (RegWrite, MemWrite, ResultSrc)
//   ex_mem_data_t : EX/MEM payload (ALUResult, WriteData, PCPlus4, ExtImm, Rd)
//   occ_t         : occupancy of a two-entry skid stage
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [63:0] alu_result;
        logic [63:0] write_data;
        logic [63:0] pc_plus4;
        logic [63:0] ext_imm;
        logic [4:0]  rd;
    } ex_mem_data_t;

    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,   // main empty, skid empty
        OCC_ONE   = 2'd1,   // main valid, skid empty
        OCC_FULL  = 2'd2,   // main valid, skid valid
        OCC_BAD   = 2'd3    // skid valid without main: never entered
    } occ_t;

    function automatic occ_t occ_of(input logic main_v, input logic skid_v);
        occ_t occ;
        if (main_v && skid_v)
            occ = OCC_FULL;
        else if (main_v)
            occ = OCC_ONE;
        else if (!skid_v)
            occ = OCC_EMPTY;
        else
            occ = OCC_BAD;
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One storage entry of the skid stage: valid bit, control bundle, payload.
//   clk, rst  : clock and synchronous active-high reset
//   i_clr     : invalidate the entry (ctrl zeroed; data zeroed if CLR_DATA)
//   i_load    : capture i_ctrl/i_data and mark valid (i_clr wins)
//   o_valid, o_ctrl, o_data : registered entry contents
// ---------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CTRL_W   = 4,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Ctrl is always cleared together with valid so an empty slot can never
    // carry RegWrite/MemWrite downstream.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end
    end

    generate
        if (CLR_DATA) begin : g_data_clr
            always_ff @(posedge clk) begin
                if (rst || i_clr)
                    r_data <= '0;
                else if (i_load)
                    r_data <= i_data;
            end
        end else begin : g_data_hold
            // No reset on the wide payload; it is only meaningful when valid.
            always_ff @(posedge clk) begin
                if (i_load && !i_clr && !rst)
                    r_data <= i_data;
            end
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Elastic pipeline register with two-entry skid storage, flush and a
// saturating stall-cycle counter. Full throughput with a registered in_ready.
//   clk, rst             : clock, synchronous active-high reset
//   flush                : kill all held entries (highest priority after rst)
//   in_valid/in_ready    : upstream handshake (in_ready from a flop and rst)
//   in_data/in_ctrl      : upstream payload and control bundle
//   out_valid/out_ready  : downstream handshake
//   out_data/out_ctrl    : main-slot contents; out_ctrl is zero when !out_valid
//   stall_cnt            : saturating count of out_valid & ~out_ready cycles
//
// Occupancy (derived from the two slot valid bits)
//   state     | meaning
//   OCC_EMPTY | nothing held, main loads on accept
//   OCC_ONE   | main holds the head; skid catches an accept without delivery
//   OCC_FULL  | both held; in_ready low, skid moves to main on delivery
//   OCC_BAD   | unreachable; both slots cleared to recover
// ---------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = EX_MEM_DATA_W,
    parameter int CTRL_W   = EX_MEM_CTRL_W,
    parameter bit CLR_DATA = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    logic              w_acc;
    logic              w_dlv;
    occ_t              w_occ;

    logic              w_main_load;
    logic              w_main_clr;
    logic              w_skid_load;
    logic              w_skid_clr;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_d;

    logic [CNT_W-1:0]  r_stall_cnt;

    // in_ready depends only on the skid flop (and rst), never on out_ready,
    // which keeps the upstream ready path short.
    assign in_ready = ~w_skid_valid & ~rst;

    assign w_acc = in_valid & in_ready;
    assign w_dlv = w_main_valid & out_ready;
    assign w_occ = occ_of(w_main_valid, w_skid_valid);

    // The skid entry is older than anything on in_*, so it has priority
    // when refilling main.
    assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_d = w_skid_valid ? w_skid_data : in_data;

    always_comb begin
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;

        case (w_occ)
            OCC_EMPTY: begin
                w_main_load = w_acc;
            end
            OCC_ONE: begin
                if (w_dlv) begin
                    if (w_acc)
                        w_main_load = 1'b1;
                    else
                        w_main_clr = 1'b1;
                end else if (w_acc) begin
                    w_skid_load = 1'b1;
                end
            end
            OCC_FULL: begin
                if (w_dlv) begin
                    w_main_load = 1'b1;
                    w_skid_clr  = 1'b1;
                end
            end
            default: begin
                w_main_clr = 1'b1;
                w_skid_clr = 1'b1;
            end
        endcase

        // Flush discards both slots and any entry accepted this cycle; the
        // delivery happening this cycle is unaffected since out_* are flops.
        if (flush) begin
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end
    end

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_main_clr),
        .i_load  (w_main_load),
        .i_ctrl  (w_main_ctrl_d),
        .i_data  (w_main_data_d),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (CLR_DATA)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_skid_clr),
        .i_load  (w_skid_load),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    // Only rst clears the counter; flush leaves it running.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_main_valid && !out_ready && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_ctrl;
    assign out_data  = w_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_stall = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .CLR_DATA (1'b1),
        .CNT_W    (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    // One clock cycle. Outputs are sampled at the falling edge (inputs already
    // settled); the model then predicts what the coming rising edge does.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            exp_stall = 0;
        end else begin
            n_chk++;
            if (!out_valid && out_ctrl !== '0) begin
                n_fail++;
                $display("FAIL empty_ctrl: out_ctrl=%h required 0 while out_valid=0", out_ctrl);
            end
            if (out_valid && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: delivered ctrl=%h data=%h, none expected", out_ctrl, out_data);
                end else begin
                    e = sb.pop_front();
                    if ({out_ctrl, out_data} !== e) begin
                        n_fail++;
                        $display("FAIL sb_order: got ctrl=%h data=%h required ctrl=%h data=%h",
                                 out_ctrl, out_data, e.c, e.d);
                    end
                end
            end
            if (out_valid && !out_ready && exp_stall < 15)
                exp_stall++;
            if (flush)
                sb.delete();
            else if (in_valid && in_ready)
                sb.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_ctrl  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_chk += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        if (out_ctrl !== '0)    begin n_fail++; $display("FAIL rst_ctrl: got %h required 0", out_ctrl); end
        if (out_data !== '0)    begin n_fail++; $display("FAIL rst_data: got %h required 0", out_data); end
        if (stall_cnt !== '0)   begin n_fail++; $display("FAIL rst_stall: got %0d required 0", stall_cnt); end
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(k);
            in_ctrl  = 4'hF;
            tick();
            n_chk += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b required 1", k, out_valid); end
            if (out_data !== DW'(k)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h required %h", k, out_data, DW'(k)); end
            if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL stream_ready[%0d]: got %b required 1", k, in_ready); end
        end
        idle_inputs();
        tick();
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h00A1; in_ctrl = 4'h1; tick();
        in_data = 16'h00B2; in_ctrl = 4'h2; tick();
        in_data = 16'h00C3; in_ctrl = 4'h3; tick();
        tick();
        n_chk += 3;
        if (out_data !== 16'h00A1) begin n_fail++; $display("FAIL bp_head: got %h required 00a1", out_data); end
        if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL bp_ready: got %b required 0", in_ready); end
        if (stall_cnt !== NW'(3))  begin n_fail++; $display("FAIL bp_stall: got %0d required 3", stall_cnt); end
        out_ready = 1'b1;
        tick();
        n_chk++;
        if (out_data !== 16'h00B2) begin n_fail++; $display("FAIL bp_second: got %h required 00b2", out_data); end
        tick();
        idle_inputs();
        n_chk++;
        if (out_data !== 16'h00C3) begin n_fail++; $display("FAIL bp_third: got %h required 00c3", out_data); end
        tick();
        n_chk += 3;
        if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL bp_empty: out_valid=%b required 0", out_valid); end
        if (sb.size() != 0)       begin n_fail++; $display("FAIL bp_lost: %0d entries never delivered, required 0", sb.size()); end
        if (stall_cnt !== NW'(3)) begin n_fail++; $display("FAIL bp_stall_final: got %0d required 3", stall_cnt); end
    endtask

    task automatic test_flush_full();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111; in_ctrl = 4'hC; tick();
        in_data = 16'h2222; in_ctrl = 4'hD; tick();
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_full: in_ready=%b required 0", in_ready); end
        flush = 1'b1; in_data = 16'h3333; in_ctrl = 4'hE;
        tick();
        idle_inputs();
        n_chk += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b required 0", out_valid); end
        if (out_ctrl !== '0)    begin n_fail++; $display("FAIL flush_ctrl: got %h required 0", out_ctrl); end
        if (out_data !== '0)    begin n_fail++; $display("FAIL flush_data: got %h required 0", out_data); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL flush_ready: got %b required 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: out_valid=%b data=%h required 0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_bubble();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0055; in_ctrl = 4'b0011;
        tick();
        idle_inputs();
        n_chk++;
        if (out_ctrl !== 4'b0011) begin n_fail++; $display("FAIL bubble_held: got %b required 0011", out_ctrl); end
        out_ready = 1'b1;
        tick();
        n_chk += 2;
        if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL bubble_valid: got %b required 0", out_valid); end
        if (out_ctrl !== 4'b0000) begin n_fail++; $display("FAIL bubble_ctrl: got %b required 0000", out_ctrl); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0777; in_ctrl = 4'h5;
        tick();
        idle_inputs();
        repeat (20) tick();
        n_chk++;
        if (stall_cnt !== NW'(15)) begin n_fail++; $display("FAIL sat_value: got %0d required 15", stall_cnt); end
        repeat (3) tick();
        n_chk++;
        if (stall_cnt !== NW'(15)) begin n_fail++; $display("FAIL sat_hold: got %0d required 15", stall_cnt); end
        flush = 1'b1; tick(); flush = 1'b0;
        n_chk++;
        if (stall_cnt !== NW'(15)) begin n_fail++; $display("FAIL sat_flush_keeps: got %0d required 15", stall_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL sat_rst: got %0d required 0", stall_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA; in_ctrl = 4'hF; tick();
        in_data = 16'hBBBB; tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        n_chk += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
        if (out_ctrl !== '0)    begin n_fail++; $display("FAIL midrst_ctrl: got %h required 0", out_ctrl); end
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL midrst_ready: got %b required 0", in_ready); end
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        n_chk += 2;
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_release: got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_lost: out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_data   = DW'($urandom);
            in_ctrl   = CW'($urandom);
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (4) tick();
        n_chk += 2;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d entries never delivered, required 0", sb.size()); end
        if (stall_cnt !== NW'(exp_stall)) begin n_fail++; $display("FAIL b2b_stall: got %0d required %0d", stall_cnt, exp_stall); end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_bubble();
        test_saturation();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
